// File: rtl/binarize_pack.sv
// binarize_pack: accumulates per-neuron popcounts, thresholds to one bit, packs bits LSB-first into words.
// Optional BINPACK_SAT_EN: saturating accumulator with sticky ovf (otherwise wraps, ovf stays 0).
module binarize_pack #(
  parameter int POP_W = 9,
  parameter int ACC_W = 16,
  parameter int OUT_W = 256,
  parameter int CNT_W = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop_valid,
  output logic             pop_ready,
  input  logic [POP_W-1:0] pop_in,
  input  logic             pop_last,
  input  logic [ACC_W-1:0] thresh,
  input  logic             flush,
  output logic [OUT_W-1:0] xo,
  output logic             xo_valid,
  input  logic             xo_ready,
  output logic [CNT_W-1:0] xo_count,
  output logic             ovf
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, total;
  logic [OUT_W-1:0] shreg_q, shreg_d, xo_q, xo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, xo_count_q, xo_count_d;
  logic             ovf_q, ovf_d, fire, act, sat;
  assign pop_ready = (state_q == FILL) && !rst;
  assign fire      = pop_valid && pop_ready;
`ifdef BINPACK_SAT_EN
  logic [ACC_W:0] sum;
  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(pop_in);
  assign sat   = sum[ACC_W];
  assign total = sat ? '1 : sum[ACC_W-1:0];
`else
  assign sat   = 1'b0;
  assign total = acc_q + ACC_W'(pop_in);
`endif
  assign act = total >= thresh;
  // The new bit is packed before the word-complete/flush decision so both land in one word.
  always_comb begin
    state_d    = state_q;
    acc_d      = fire ? (pop_last ? '0 : total) : acc_q;
    shreg_d    = (fire && pop_last) ? (shreg_q | (OUT_W'(act) << cnt_q)) : shreg_q;
    cnt_d      = (fire && pop_last) ? cnt_q + 1'b1 : cnt_q;
    xo_d       = xo_q;
    xo_count_d = xo_count_q;
    ovf_d      = ovf_q | (fire & sat);
    if (state_q == FILL && (cnt_d == CNT_W'(OUT_W) || (flush && cnt_d != '0))) begin
      xo_d       = shreg_d;
      xo_count_d = cnt_d;
      shreg_d    = '0;
      cnt_d      = '0;
      state_d    = HOLD;
    end else if (state_q == HOLD && xo_ready) begin
      state_d = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      acc_q      <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      xo_q       <= '0;
      xo_count_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      xo_q       <= xo_d;
      xo_count_q <= xo_count_d;
      ovf_q      <= ovf_d;
    end
  end
  assign xo       = xo_q;
  assign xo_valid = state_q == HOLD;
  assign xo_count = xo_count_q;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_binarize_pack.sv
// tb_binarize_pack: directed and random stimulus against a queue-based reference model.
module tb_binarize_pack;
  localparam int POP_W = 9;
  localparam int ACC_W = 10;
  localparam int OUT_W = 8;
  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam int MAX   = (1 << ACC_W) - 1;
  logic             clk = 1'b0;
  logic             rst, pop_valid, pop_last, flush, xo_ready;
  logic             pop_ready, xo_valid, ovf;
  logic [POP_W-1:0] pop_in;
  logic [ACC_W-1:0] thresh;
  logic [OUT_W-1:0] xo;
  logic [CNT_W-1:0] xo_count;
  int n_checks = 0;
  int n_fail = 0;
  bit             m_hold, m_ovf;
  int             m_acc, m_cnt;
  bit             m_bits[$];
  logic [OUT_W-1:0] m_xo;
  always #5 clk = ~clk;
  binarize_pack #(.POP_W(POP_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_in(pop_in),
    .pop_last(pop_last), .thresh(thresh), .flush(flush), .xo(xo), .xo_valid(xo_valid),
    .xo_ready(xo_ready), .xo_count(xo_count), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Reference: neuron totals as plain integers, activation bits held in a queue until a word is emitted.
  task automatic model_step();
    int tot;
    if (rst) begin
      m_hold = 0; m_ovf = 0; m_acc = 0; m_cnt = 0; m_xo = '0;
      m_bits.delete();
      return;
    end
    if (m_hold) begin
      if (xo_ready) m_hold = 0;
      return;
    end
    if (pop_valid) begin
      tot = m_acc + int'(pop_in);
`ifdef BINPACK_SAT_EN
      if (tot > MAX) begin
        tot = MAX;
        m_ovf = 1;
      end
`else
      tot = tot % (MAX + 1);
`endif
      if (pop_last) begin
        m_bits.push_back(tot >= int'(thresh));
        m_acc = 0;
      end else m_acc = tot;
    end
    if (m_bits.size() == OUT_W || (flush && m_bits.size() > 0)) begin
      m_xo = '0;
      foreach (m_bits[i]) m_xo[i] = m_bits[i];
      m_cnt = m_bits.size();
      m_bits.delete();
      m_hold = 1;
    end
  endtask
  task automatic cyc(input bit r, input bit v, input bit last, input bit fl, input bit rdy,
                     input int p, input int th);
    rst = r; pop_valid = v; pop_last = last; flush = fl; xo_ready = rdy;
    pop_in = POP_W'(p); thresh = ACC_W'(th);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pop_ready", pop_ready, !m_hold && !rst);
    check("xo_valid", xo_valid, m_hold);
    check("xo", xo, m_xo);
    check("xo_count", xo_count, m_cnt);
    check("ovf", ovf, m_ovf);
  endtask
  task automatic neuron(input int p, input int th);
    cyc(0, 1, 1, 0, 0, p, th);
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 5, 0);
    check("rst_ready", pop_ready, 0);
    check("rst_xo", xo, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t1_not_yet_valid", xo_valid, 0);
      neuron(200, (i % 2) ? 256 : 128);
    end
    check("t1_valid", xo_valid, 1);
    check("t1_xo", xo, 8'h55);
    check("t1_cnt", xo_count, 8);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 1, 0);
    check("t1_hold_ready", pop_ready, 0);
    check("t1_hold_xo", xo, 8'h55);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("t1_release_valid", xo_valid, 0);
    check("t1_release_ready", pop_ready, 1);
    for (int t = 612; t <= 613; t++) begin
      cyc(0, 1, 0, 0, 0, 256, 0);
      cyc(0, 1, 0, 0, 0, 256, 0);
      neuron(100, t);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t2_xo", xo, 8'h01);
    check("t2_cnt", xo_count, 2);
    cyc(0, 0, 0, 0, 1, 0, 0);
    neuron(10, 5);
    neuron(10, 5);
    neuron(10, 20);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t3_xo", xo, 8'h03);
    check("t3_cnt", xo_count, 3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("t3_empty_flush", xo_valid, 0);
    cyc(0, 1, 0, 0, 0, 511, 0);
    cyc(0, 1, 0, 0, 0, 511, 0);
    cyc(0, 1, 1, 1, 0, 2, MAX);
`ifdef BINPACK_SAT_EN
    check("t4_xo_sat", xo, 8'h01);
    check("t4_ovf_sat", ovf, 1);
`else
    check("t4_xo_wrap", xo, 8'h00);
    check("t4_ovf_wrap", ovf, 0);
`endif
    check("t4_cnt", xo_count, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) neuron(10, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("t5_rst_xo", xo, 0);
    check("t5_rst_cnt", xo_count, 0);
    check("t5_rst_valid", xo_valid, 0);
    for (int i = 0; i < 8; i++) neuron(10, (i >= 4) ? 0 : 20);
    check("t5_fresh_xo", xo, 8'hF0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 511)), int'($urandom_range(0, MAX)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/binarize_pack.md
# binarize_pack

Sign-activation and bit-packing stage for the binarized inference datapath. Consumes per-chunk popcounts from the XNOR-popcount array, accumulates them per neuron across fan-in chunks, and thresholds each neuron total to one activation bit. Packs successive bits LSB-first into OUT_W-bit words that feed the next layer's `xi` operand, with valid/ready backpressure.

## Interface
Parameters:
- `POP_W`, 9, width of each incoming popcount (256-input array → 9).
- `ACC_W`, 16, neuron accumulator and threshold width (unsigned).
- `OUT_W`, 256, bits per packed output word.
- `CNT_W`, $clog2(OUT_W+1), width of `xo_count`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pop_valid`  in  1  popcount chunk presented.
- `pop_ready`  out  1  block accepts a chunk this cycle.
- `pop_in`  in  POP_W  chunk popcount.
- `pop_last`  in  1  chunk is the final chunk of the current neuron.
- `thresh`  in  ACC_W  neuron threshold; sampled only on an accepted `pop_last` beat.
- `flush`  in  1  emit the partially filled word.
- `xo`  out  OUT_W  packed activation word; bit i = i-th neuron of the word.
- `xo_valid`  out  1  `xo` holds a word.
- `xo_ready`  in  1  downstream accepts `xo`.
- `xo_count`  out  CNT_W  number of valid bits in `xo` (OUT_W for full word).
- `ovf`  out  1  sticky accumulator-overflow flag.

## Operation
- Two states: FILL and HOLD. Reset → FILL.
- `pop_ready` = 1 in FILL and `rst` low; 0 in HOLD.
- Accepted beat = `pop_valid && pop_ready`.
- Accepted beat with `pop_last`=0: `acc <= acc + pop_in` (zero-extended).
- Accepted beat with `pop_last`=1: `total = acc + pop_in`; bit = (`total >= thresh`), unsigned; bit written into `shreg[bit_cnt]`; `bit_cnt++`; `acc <= 0`.
- Word completes when `bit_cnt` reaches OUT_W: `xo <= shreg` (including the new bit), `xo_count <= OUT_W`, `xo_valid <= 1`, `bit_cnt <= 0`, `shreg <= 0`, state → HOLD.
- `flush` in FILL with `bit_cnt > 0` (counting any bit added the same cycle): emit partial word, upper bits zero, `xo_count` = bits held, state → HOLD. `flush` with zero bits held: ignored. `flush` in HOLD: ignored (not queued).
- Simultaneous accepted `pop_last` and `flush`: bit is packed first, then flushed in the same word.
- `flush` does not clear `acc`; a neuron in progress continues into the next word.
- HOLD: `xo`, `xo_count` stable; on `xo_ready` → `xo_valid <= 0`, state → FILL.
- Accumulator overflow behaviour per Configuration.

## Timing
- Reset values: `xo`=0, `xo_valid`=0, `xo_count`=0, `ovf`=0, `acc`=0, `bit_cnt`=0, state FILL; `pop_ready`=0 while `rst` high.
- Latency: `xo_valid` rises the cycle after the accepted beat completing the word (or after `flush`).
- One-cycle bubble: `pop_ready` returns high the cycle after the `xo_valid && xo_ready` handshake.
- `rst` mid-word or in HOLD discards all partial state and any held word; no output is produced.
- Throughput: one chunk per cycle in FILL.

## Configuration
- `BINPACK_SAT_EN` defined: `acc` and `total` saturate at 2^ACC_W−1; any saturation sets `ovf` (cleared only by `rst`).
- Not defined: `acc` wraps modulo 2^ACC_W; `ovf` tied 0.

## Test plan
- OUT_W=8, 8 neurons each one chunk `pop_in`=200, `thresh` alternating 128/256 → `xo`=8'h55, `xo_count`=8, `xo_valid` one cycle after 8th beat.
- 1 neuron, 3 chunks 256,256,100 (`pop_last` on 3rd), `thresh`=612 → bit 1; repeat with `thresh`=613 → bit 0.
- OUT_W=8, 3 neurons bits 1,1,0 then `flush` → `xo`=8'h03, `xo_count`=3; `flush` on empty → no `xo_valid`.
- Hold `xo_ready`=0 for 5 cycles after word → `pop_ready`=0, `xo` stable; `xo_ready`=1 → `xo_valid`=0 next cycle, `pop_ready`=1.
- ACC_W=9, chunks 511,1 with `BINPACK_SAT_EN` → total 511, `ovf`=1; without → total 0, `ovf`=0.
- Assert `rst` after 5 of 8 bits → all outputs 0; next 8 neurons form a fresh word with no stale bits.
